// File: rtl/zc_pkg.sv
// -----------------------------------------------------------------------------
// zc_pkg
// Shared types and width helpers for the zero-count framer.
//   ZC_W / zc_t   : per-word zero count (0..32 fits in 6 bits)
//   acc_width()   : bits needed to hold a frame's total zero count
//   wc_width()    : bits needed to hold a frame's word count
//   frame_rec_t   : completed-frame record sized for the default MAX_WORDS
// -----------------------------------------------------------------------------
package zc_pkg;

   localparam int ZC_W          = 6;
   localparam int WORD_BITS     = 32;
   localparam int DEF_MAX_WORDS = 256;

   typedef logic [ZC_W-1:0] zc_t;

   // Largest possible sum is max_words * 32, so the accumulator never wraps.
   function automatic int acc_width(input int max_words);
      return $clog2(max_words * WORD_BITS + 1);
   endfunction

   function automatic int wc_width(input int max_words);
      return $clog2(max_words + 1);
   endfunction

   localparam int DEF_ACC_W = acc_width(DEF_MAX_WORDS);
   localparam int DEF_WC_W  = wc_width(DEF_MAX_WORDS);

   typedef struct packed {
      logic [DEF_ACC_W-1:0] sum;
      logic [DEF_WC_W-1:0]  words;
      logic                 sat;
   } frame_rec_t;

endpackage

// File: rtl/zc_rec_fifo.sv
// -----------------------------------------------------------------------------
// zc_rec_fifo
// Synchronous DEPTH-entry FIFO of frame records with a registered head.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is silently refused (the parent accounts for it).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, push_data record to enqueue
//   pop             dequeue the head (ignored when empty)
//   head            registered front record
//   head_valid      registered "FIFO not empty"
//   full            all DEPTH entries occupied
// -----------------------------------------------------------------------------
module zc_rec_fifo
   import zc_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type rec_t = frame_rec_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  rec_t push_data,
   input  logic pop,
   output rec_t head,
   output logic head_valid,
   output logic full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   rec_t             mem [DEPTH];
   logic [PTR_W-1:0] rd_r;
   logic [PTR_W-1:0] wr_r;
   logic [CNT_W-1:0] cnt_r;
   rec_t             head_r;
   logic             head_vld_r;

   logic             pop_ok;
   logic             push_ok;
   logic [PTR_W-1:0] rd_nxt;
   logic [CNT_W-1:0] remain;
   logic [CNT_W-1:0] cnt_nxt;
   rec_t             head_nxt;

   assign full = (cnt_r == CNT_W'(DEPTH));

   always_comb begin
      pop_ok  = pop & head_vld_r;
      push_ok = push & (~full | pop_ok);
      rd_nxt  = rd_r + PTR_W'(pop_ok);
      remain  = cnt_r - CNT_W'(pop_ok);
      cnt_nxt = remain + CNT_W'(push_ok);
      // Next head: an entry already stored wins; only when nothing is left
      // after the pop does the incoming record become the head.
      if (remain != '0) begin
         head_nxt = mem[rd_nxt];
      end else if (push_ok) begin
         head_nxt = push_data;
      end else begin
         head_nxt = head_r;
      end
   end

   // Storage array carries data only and needs no reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_r] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_r       <= '0;
         wr_r       <= '0;
         cnt_r      <= '0;
         head_r     <= '0;
         head_vld_r <= 1'b0;
      end else begin
         rd_r       <= rd_nxt;
         wr_r       <= wr_r + PTR_W'(push_ok);
         cnt_r      <= cnt_nxt;
         head_r     <= head_nxt;
         head_vld_r <= (cnt_nxt != '0);
      end
   end

   assign head       = head_r;
   assign head_valid = head_vld_r;

endmodule

// File: rtl/zero_count_framer.sv
// -----------------------------------------------------------------------------
// zero_count_framer
// Accumulates per-word zero counts into per-frame records (total zeros, word
// count, over-length flag), queues them and presents them on valid/ready.
// The upstream never stalls, so records that find the queue full are dropped
// and counted.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid, in_y, in_last       per-word zero count stream, frame-last tag
//   out_valid, out_ready          record handshake
//   out_sum, out_words, out_sat   head record fields
//   overflow_r, drop_cnt_r        sticky drop flag, saturating drop counter
//   clr_ovf                       clears overflow_r / drop_cnt_r
// -----------------------------------------------------------------------------
module zero_count_framer
   import zc_pkg::*;
#(
   parameter  int MAX_WORDS = 256,
   parameter  int DEPTH     = 4,
   parameter  int DROP_W    = 8,
   localparam int ACC_W     = acc_width(MAX_WORDS),
   localparam int WC_W      = wc_width(MAX_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ZC_W-1:0]   in_y,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [WC_W-1:0]   out_words,
   output logic              out_sat,
   output logic              overflow_r,
   output logic [DROP_W-1:0] drop_cnt_r,
   input  logic              clr_ovf
);

   // Record sized for this instance's MAX_WORDS.
   typedef struct packed {
      logic [ACC_W-1:0] sum;
      logic [WC_W-1:0]  words;
      logic             sat;
   } rec_t;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (&v) ? v : v + DROP_W'(1);
   endfunction

   logic [ACC_W-1:0] acc_r;
   logic [WC_W-1:0]  wc_r;
   logic             sat_r;

   logic             room;
   logic [ACC_W-1:0] nxt_sum;
   logic [WC_W-1:0]  nxt_wc;
   logic             nxt_sat;
   logic             rec_push;
   rec_t             rec_in;
   rec_t             rec_head;
   logic             fifo_full;
   logic             pop;
   logic             drop;

   // ---- Stage: per-word accumulate ---------------------------------------
   always_comb begin
      room     = (wc_r < WC_W'(MAX_WORDS));
      nxt_sum  = room ? acc_r + ACC_W'(in_y) : acc_r;
      nxt_wc   = room ? wc_r + WC_W'(1) : wc_r;
      nxt_sat  = sat_r | ~room;
      rec_push = in_valid & in_last;
      rec_in   = '{sum: nxt_sum, words: nxt_wc, sat: nxt_sat};
   end

   // Closing a frame clears the accumulator in the same cycle so the next
   // frame's first word can follow immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r <= '0;
         wc_r  <= '0;
         sat_r <= 1'b0;
      end else if (in_valid) begin
         if (in_last) begin
            acc_r <= '0;
            wc_r  <= '0;
            sat_r <= 1'b0;
         end else begin
            acc_r <= nxt_sum;
            wc_r  <= nxt_wc;
            sat_r <= nxt_sat;
         end
      end
   end

   // ---- Stage: record queue ----------------------------------------------
   assign pop  = out_valid & out_ready;
   assign drop = rec_push & fifo_full & ~pop;

   zc_rec_fifo #(
      .DEPTH (DEPTH),
      .rec_t (rec_t)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (rec_push),
      .push_data  (rec_in),
      .pop        (pop),
      .head       (rec_head),
      .head_valid (out_valid),
      .full       (fifo_full)
   );

   // A drop coinciding with a clear restarts the count at one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_r <= 1'b0;
         drop_cnt_r <= '0;
      end else if (drop) begin
         overflow_r <= 1'b1;
         drop_cnt_r <= clr_ovf ? DROP_W'(1) : sat_inc(drop_cnt_r);
      end else if (clr_ovf) begin
         overflow_r <= 1'b0;
         drop_cnt_r <= '0;
      end
   end

   // ---- Stage: output mapping --------------------------------------------
   assign out_sum   = rec_head.sum;
   assign out_words = rec_head.words;
   assign out_sat   = rec_head.sat;

endmodule

// File: tb/tb_zero_count_framer.sv
module tb_zero_count_framer;
   import zc_pkg::*;

   localparam int DEPTH  = 4;
   localparam int DROP_W = 8;
   localparam int MAXW_A = 256;
   localparam int MAXW_B = 4;
   localparam int ACC_A  = acc_width(MAXW_A);
   localparam int WC_A   = wc_width(MAXW_A);
   localparam int ACC_B  = acc_width(MAXW_B);
   localparam int WC_B   = wc_width(MAXW_B);
   localparam int DROP_MAX = (1 << DROP_W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       in_valid;
   logic [5:0] in_y;
   logic       in_last;
   logic       out_ready;
   logic       clr_ovf;

   logic              va, sta, ovfa;
   logic [ACC_A-1:0]  sa;
   logic [WC_A-1:0]   wa;
   logic [DROP_W-1:0] dca;
   logic              vb, stb, ovfb;
   logic [ACC_B-1:0]  sb;
   logic [WC_B-1:0]   wb;
   logic [DROP_W-1:0] dcb;

   zero_count_framer #(.MAX_WORDS(MAXW_A), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_y(in_y), .in_last(in_last),
      .out_valid(va), .out_ready(out_ready), .out_sum(sa), .out_words(wa),
      .out_sat(sta), .overflow_r(ovfa), .drop_cnt_r(dca), .clr_ovf(clr_ovf));

   zero_count_framer #(.MAX_WORDS(MAXW_B), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_y(in_y), .in_last(in_last),
      .out_valid(vb), .out_ready(out_ready), .out_sum(sb), .out_words(wb),
      .out_sat(stb), .overflow_r(ovfb), .drop_cnt_r(dcb), .clr_ovf(clr_ovf));

   always @(posedge clk) begin
      if (rst && in_valid) begin
         assert (in_y <= 6'd32) else $error("illegal in_y %0d", in_y);
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (queue of whole-frame records) -------
   typedef struct {
      int sum;
      int words;
      bit sat;
   } mrec_t;

   mrec_t mq[$];
   int    m_sum, m_words, m_drops;
   bit    m_sat, m_ovf;

   task automatic model_step();
      mrec_t r;
      if (!rst) begin
         mq.delete();
         m_sum = 0; m_words = 0; m_sat = 0; m_ovf = 0; m_drops = 0;
         return;
      end
      if (mq.size() > 0 && out_ready) mq.delete(0);
      if (clr_ovf) begin
         m_ovf = 0;
         m_drops = 0;
      end
      if (in_valid) begin
         if (m_words < MAXW_A) begin
            m_sum += int'(in_y);
            m_words++;
         end else begin
            m_sat = 1;
         end
         if (in_last) begin
            r.sum = m_sum; r.words = m_words; r.sat = m_sat;
            if (mq.size() < DEPTH) mq.push_back(r);
            else begin
               m_ovf = 1;
               if (m_drops < DROP_MAX) m_drops++;
            end
            m_sum = 0; m_words = 0; m_sat = 0;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input int y, input bit l, input bit rdy, input bit clr);
      in_valid = v; in_y = 6'(y); in_last = l; out_ready = rdy; clr_ovf = clr;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic chk_a(input string tag, input bit ev, input int es, input int ew,
                        input bit esat, input bit eovf, input int edrop);
      chk({tag, ".valid"}, va, ev);
      if (ev) begin
         chk({tag, ".sum"}, sa, es);
         chk({tag, ".words"}, wa, ew);
         chk({tag, ".sat"}, sta, esat);
      end
      chk({tag, ".ovf"}, ovfa, eovf);
      chk({tag, ".drop"}, dca, edrop);
   endtask

   // ---------------- directed vector table --------------------------------
   typedef struct {
      bit v; int y; bit l; bit rdy; bit clr;
      bit ev; int es; int ew; bit esat; bit eovf; int edrop;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit v, int y, bit l, bit rdy, bit clr,
                      bit ev, int es, int ew, bit esat, bit eovf, int edrop);
      vec_t t;
      t.v = v; t.y = y; t.l = l; t.rdy = rdy; t.clr = clr;
      t.ev = ev; t.es = es; t.ew = ew; t.esat = esat; t.eovf = eovf; t.edrop = edrop;
      tbl.push_back(t);
   endtask

   int rdy_pct;

   initial begin
      // single-word frame, then pop
      add(1, 32, 1, 0, 0,  1, 32, 1, 0, 0, 0);
      add(0,  0, 0, 1, 0,  0,  0, 0, 0, 0, 0);
      // four-word frame then immediate one-word frame
      add(1, 32, 0, 1, 0,  0,  0, 0, 0, 0, 0);
      add(1,  0, 0, 1, 0,  0,  0, 0, 0, 0, 0);
      add(1, 16, 0, 1, 0,  0,  0, 0, 0, 0, 0);
      add(1,  7, 1, 1, 0,  1, 55, 4, 0, 0, 0);
      add(1,  3, 1, 1, 0,  1,  3, 1, 0, 0, 0);
      add(0,  0, 0, 1, 0,  0,  0, 0, 0, 0, 0);
      add(0,  0, 1, 1, 0,  0,  0, 0, 0, 0, 0);   // in_last without in_valid
      // backpressure: five frames into four slots
      add(1,  1, 1, 0, 0,  1,  1, 1, 0, 0, 0);
      add(1,  2, 1, 0, 0,  1,  1, 1, 0, 0, 0);
      add(1,  3, 1, 0, 0,  1,  1, 1, 0, 0, 0);
      add(1,  4, 1, 0, 0,  1,  1, 1, 0, 0, 0);
      add(1,  5, 1, 0, 0,  1,  1, 1, 0, 1, 1);
      add(0,  0, 0, 1, 0,  1,  2, 1, 0, 1, 1);
      add(0,  0, 0, 1, 0,  1,  3, 1, 0, 1, 1);
      add(0,  0, 0, 1, 0,  1,  4, 1, 0, 1, 1);
      add(0,  0, 0, 1, 0,  0,  0, 0, 0, 1, 1);
      add(0,  0, 0, 1, 1,  0,  0, 0, 0, 0, 0);
      // drop coinciding with clear
      add(1,  1, 1, 0, 0,  1,  1, 1, 0, 0, 0);
      add(1,  2, 1, 0, 0,  1,  1, 1, 0, 0, 0);
      add(1,  3, 1, 0, 0,  1,  1, 1, 0, 0, 0);
      add(1,  4, 1, 0, 0,  1,  1, 1, 0, 0, 0);
      add(1,  5, 1, 0, 0,  1,  1, 1, 0, 1, 1);
      add(1,  6, 1, 0, 0,  1,  1, 1, 0, 1, 2);
      add(1,  7, 1, 0, 1,  1,  1, 1, 0, 1, 1);
      add(0,  0, 0, 0, 1,  1,  1, 1, 0, 0, 0);
      add(0,  0, 0, 1, 0,  1,  2, 1, 0, 0, 0);
      add(0,  0, 0, 1, 0,  1,  3, 1, 0, 0, 0);
      add(0,  0, 0, 1, 0,  1,  4, 1, 0, 0, 0);
      add(0,  0, 0, 1, 0,  0,  0, 0, 0, 0, 0);

      // reset state
      do_reset();
      rst = 1'b0;
      #1;
      chk("rst.valid", va, 0);  chk("rst.sum", sa, 0);   chk("rst.words", wa, 0);
      chk("rst.sat", sta, 0);   chk("rst.ovf", ovfa, 0); chk("rst.drop", dca, 0);
      chk("rst4.valid", vb, 0); chk("rst4.sum", sb, 0);  chk("rst4.sat", stb, 0);
      chk("rst4.ovf", ovfb, 0); chk("rst4.drop", dcb, 0); chk("rst4.words", wb, 0);
      rst = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].y, tbl[i].l, tbl[i].rdy, tbl[i].clr);
         tick();
         chk_a($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].es, tbl[i].ew,
               tbl[i].esat, tbl[i].eovf, tbl[i].edrop);
      end

      // full FIFO with a pop in the same cycle as the fifth push
      for (int k = 1; k <= 4; k++) begin
         drive(1, k, 1, 0, 0);
         tick();
      end
      drive(1, 5, 1, 1, 0);
      tick();
      chk_a("full_pop", 1, 2, 1, 0, 0, 0);
      for (int k = 3; k <= 5; k++) begin
         drive(0, 0, 0, 1, 0);
         tick();
         chk_a($sformatf("full_pop.drain%0d", k), 1, k, 1, 0, 0, 0);
      end
      drive(0, 0, 0, 1, 0);
      tick();
      chk_a("full_pop.empty", 0, 0, 0, 0, 0, 0);

      // MAX_WORDS=4 instance: over-length frame, then a normal one
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         drive(1, 32, (k == 6), 0, 0);
         tick();
      end
      chk("max4.valid", vb, 1); chk("max4.sum", sb, 128);
      chk("max4.words", wb, 4); chk("max4.sat", stb, 1);
      chk("max256.sum", sa, 192); chk("max256.words", wa, 6); chk("max256.sat", sta, 0);
      drive(1, 0, 1, 1, 0);
      tick();
      chk("max4.next.valid", vb, 1); chk("max4.next.sum", sb, 0);
      chk("max4.next.words", wb, 1); chk("max4.next.sat", stb, 0);
      drive(0, 0, 0, 1, 0);
      tick();
      chk("max4.empty", vb, 0);

      // reset in the middle of a frame with a record already queued
      drive(1, 9, 1, 0, 0);
      tick();
      chk_a("midrst.pre", 1, 9, 1, 0, 0, 0);
      drive(1, 10, 0, 0, 0);
      tick();
      tick();
      drive(0, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      chk("midrst.async.valid", va, 0);
      chk("midrst.async.sum", sa, 0);
      tick();
      rst = 1'b1;
      drive(1, 5, 1, 0, 0);
      tick();
      chk_a("midrst.rec", 1, 5, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      tick();
      chk_a("midrst.single", 0, 0, 0, 0, 0, 0);

      // drop counter saturation
      for (int k = 0; k < DEPTH + 300; k++) begin
         drive(1, 1, 1, 0, 0);
         tick();
      end
      chk("dropsat.ovf", ovfa, 1);
      chk("dropsat.cnt", dca, DROP_MAX);
      drive(0, 0, 0, 0, 1);
      tick();
      chk("dropsat.clr.ovf", ovfa, 0);
      chk("dropsat.clr.cnt", dca, 0);

      // randomized traffic against the queue model
      do_reset();
      rdy_pct = 15;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) rdy_pct = (rdy_pct == 80) ? 15 : 80;
         in_valid  = ($urandom_range(0, 99) < 65);
         in_y      = 6'($urandom_range(0, 32));
         in_last   = ($urandom_range(0, 99) < 30);
         out_ready = ($urandom_range(0, 99) < rdy_pct);
         clr_ovf   = ($urandom_range(0, 99) < 3);
         tick();
         chk("rnd.valid", va, (mq.size() > 0));
         if (mq.size() > 0) begin
            chk("rnd.sum", sa, mq[0].sum);
            chk("rnd.words", wa, mq[0].words);
            chk("rnd.sat", sta, mq[0].sat);
         end
         chk("rnd.ovf", ovfa, m_ovf);
         chk("rnd.drop", dca, m_drops);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/zero_count_framer.md
Name: zero_count_framer

Overview:
- Downstream consumer of the 32-bit zero-count stage. Takes its per-word result stream (valid plus 6-bit count, 0..32) and a frame-last tag delayed to align with it.
- Accumulates the total zero count and the word count per frame. Queues completed frame records in a small FIFO and presents them on a valid/ready interface to the stats/CSR logic.
- The upstream stage has no backpressure. This block accepts every input beat and accounts for any record it cannot store.

Parameters:
- MAX_WORDS, 256, max words counted per frame; extra words are ignored and flagged.
- DEPTH, 4, frame-record FIFO entries (power of 2, >=2).
- DROP_W, 8, width of saturating drop counter.
- Derived: ACC_W = $clog2(MAX_WORDS*32+1); WC_W = $clog2(MAX_WORDS+1).

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset: asynchronous, active-low.
- in_valid  in  1  connects to upstream valid_r.
- in_y  in  6  zeros in the word, 0..32.
- in_last  in  1  last word of frame; qualified by in_valid.
- out_valid  out  1  frame record available.
- out_ready  in  1  consumer accepts the record.
- out_sum  out  ACC_W  total zeros in the frame.
- out_words  out  WC_W  words counted in the frame.
- out_sat  out  1  frame exceeded MAX_WORDS.
- overflow_r  out  1  sticky: a record was dropped.
- drop_cnt_r  out  DROP_W  dropped records, saturating.
- clr_ovf  in  1  clears overflow_r and drop_cnt_r.

Behaviour:
- Reset (rst=0, asynchronous):
  - acc_r=0, wc_r=0, sat_r=0, FIFO empty.
  - out_valid=0, out_sum/out_words/out_sat=0, overflow_r=0, drop_cnt_r=0.
  - A partial frame in progress is discarded. Inputs are ignored while rst=0.
- Accumulate (in_valid=1):
  - If wc_r<MAX_WORDS: nxt_sum=acc_r+in_y and nxt_wc=wc_r+1.
  - Otherwise: sum and count hold, and nxt_sat=1.
  - If in_last=0: acc_r, wc_r and sat_r take the next values.
  - If in_last=1: the record {nxt_sum, nxt_wc, nxt_sat} is pushed. acc_r, wc_r and sat_r clear to 0 in the same cycle, so back-to-back frames need no bubble.
  - in_valid=0: state holds. in_last is ignored when in_valid=0.
- Width rules:
  - Sums are zero-extended to ACC_W and never wrap.
  - in_y>32 is illegal; the bench asserts it, and RTL behaviour is unspecified.
- Latency: in_last beat at cycle N gives out_valid=1 at N+1 when the FIFO was empty. Registered output, no combinational path from in_* to out_*.
- Output handshake:
  - A record pops when out_valid & out_ready.
  - out_* are stable while out_valid=1 and out_ready=0.
  - Records are delivered in frame-completion order.
- Full FIFO:
  - Push with a pop in the same cycle is accepted.
  - Push with no pop: the record is dropped, overflow_r<=1, and drop_cnt_r increments, saturating at all-ones.
- clr_ovf:
  - Clears overflow_r and drop_cnt_r at the next edge.
  - If a drop happens in the same cycle, the drop wins: overflow_r=1, drop_cnt_r=1.
- Empty FIFO with a simultaneous push and out_ready: no bypass; the record appears at N+1.

Decomposition:
- Package zc_pkg holds:
  - ZC_W=6 and typedef zc_t.
  - Functions for the ACC_W/WC_W derivations.
  - Packed struct frame_rec_t {sum, words, sat}.
- One sub-module: zc_rec_fifo, a parameterised DEPTH x frame_rec_t synchronous FIFO.
  - Registered head, push/pop/full/empty.
  - Supports push+pop when full.
- The top level holds the accumulator, the drop/overflow logic and the output mapping.

Test Plan:
- Single-word frame: in_y=32, in_last=1 at cycle N → out_valid at N+1, out_sum=32, out_words=1, out_sat=0.
- Four-word frame: in_y=32,0,16,7, last on the 4th, out_ready=1 → out_sum=55, out_words=4. An immediate next frame with in_y=3,last gives out_sum=3.
- Backpressure, DEPTH=4: out_ready=0, five one-word frames in_y=1..5 → 5th dropped, overflow_r=1, drop_cnt_r=1. Raising out_ready yields 1,2,3,4 in order. Then clr_ovf → both cleared.
- FIFO full with out_ready=1 in the same cycle as the 5th in_last → no drop, overflow_r stays 0, all five records delivered.
- MAX_WORDS=4 override: six words of in_y=32, last on the 6th → out_sum=128, out_words=4, out_sat=1. Next frame of one word in_y=0 → out_sat=0.
- Reset mid-frame: two words in_y=10, rst low for 1 cycle, then one word in_y=5 with last → single record, out_sum=5, out_words=1.
